// File: rtl/video_effects_pkg.sv
// Shared definitions for the video effects control stage and the effects stage.
package video_effects_pkg;

  localparam int unsigned DATA_W     = 16;
  localparam int unsigned EFFECT_W   = 5;
  localparam int unsigned CSR_ADDR_W = 3;
  localparam int unsigned CSR_DATA_W = 32;
  localparam int unsigned BEAT_W     = DATA_W + 2;

  localparam logic [CSR_ADDR_W-1:0] CSR_EFFECT = 3'd0;
  localparam logic [CSR_ADDR_W-1:0] CSR_DELETE = 3'd1;
  localparam logic [CSR_ADDR_W-1:0] CSR_SUBST  = 3'd2;
  localparam logic [CSR_ADDR_W-1:0] CSR_STATUS = 3'd3;
  localparam logic [CSR_ADDR_W-1:0] CSR_FRAMES = 3'd4;
  localparam logic [CSR_ADDR_W-1:0] CSR_ACTIVE = 3'd5;

  localparam int unsigned STATUS_DIRTY_BIT    = 0;
  localparam int unsigned STATUS_SIZE_ERR_BIT = 1;

  // One-hot effect selects understood by the effects stage; zero is pass-through.
  localparam logic [EFFECT_W-1:0] FX_NONE   = 5'b00000;
  localparam logic [EFFECT_W-1:0] FX_GRAY   = 5'b00001;
  localparam logic [EFFECT_W-1:0] FX_INVERT = 5'b00010;
  localparam logic [EFFECT_W-1:0] FX_DELETE = 5'b00100;
  localparam logic [EFFECT_W-1:0] FX_SUBST  = 5'b01000;
  localparam logic [EFFECT_W-1:0] FX_MIRROR = 5'b10000;

  localparam logic [DATA_W-1:0] DELETE_COLOR_RST = 16'h0000;
  localparam logic [DATA_W-1:0] SUBST_COLOR_RST  = 16'h0000;

  typedef struct packed {
    logic              sop;
    logic              eop;
    logic [DATA_W-1:0] data;
  } beat_t;

endpackage

// File: rtl/video_stream_skid.sv
// Generic Avalon-ST register slice: one output register plus one skid entry.
// o_load_c pulses on every edge that loads the output register, with the loaded payload.
module video_stream_skid #(
  parameter int unsigned W = 18
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_data,
  input  logic         i_valid,
  output logic         o_ready,
  output logic [W-1:0] o_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic         o_load_c,
  output logic [W-1:0] o_load_data_c
);

  logic         r_out_valid;
  logic [W-1:0] r_out_data;
  logic         r_skid_valid;
  logic [W-1:0] r_skid_data;
  logic         r_in_ready;

  logic         w_accept;
  logic         w_out_free;
  logic         w_load;
  logic [W-1:0] w_load_data;
  logic         w_skid_fill;
  logic         w_skid_valid_nxt;

  assign w_accept         = i_valid & r_in_ready;
  assign w_out_free       = ~r_out_valid | i_ready;
  // The skid has priority over the sink so ordering is preserved.
  assign w_load           = (r_skid_valid | w_accept) & w_out_free;
  assign w_load_data      = r_skid_valid ? r_skid_data : i_data;
  assign w_skid_fill      = w_accept & ~w_out_free & ~r_skid_valid;
  assign w_skid_valid_nxt = r_skid_valid ? ~w_out_free : w_skid_fill;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_in_ready   <= 1'b0;
    end else begin
      r_in_ready   <= ~w_skid_valid_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      if (w_skid_fill) begin
        r_skid_data <= i_data;
      end
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_load_data;
      end else if (i_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign o_ready       = r_in_ready;
  assign o_valid       = r_out_valid;
  assign o_data        = r_out_data;
  assign o_load_c      = w_load;
  assign o_load_data_c = w_load_data;

endmodule

// File: rtl/video_effects_ctrl.sv
// Effect CSR file with frame-aligned commit, stream register slice and frame-size checker
// sitting directly in front of the pixel effects stage.
module video_effects_ctrl
  import video_effects_pkg::*;
#(
  parameter int unsigned FRAME_PIXELS = 76800
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CSR_ADDR_W-1:0] avs_address,
  input  logic                  avs_read,
  input  logic                  avs_write,
  input  logic [CSR_DATA_W-1:0] avs_writedata,
  output logic [CSR_DATA_W-1:0] avs_readdata,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_valid,
  input  logic                  in_sop,
  input  logic                  in_eop,
  output logic                  in_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_valid,
  output logic                  out_sop,
  output logic                  out_eop,
  input  logic                  out_ready,
  output logic [EFFECT_W-1:0]   effect,
  output logic [DATA_W-1:0]     effect_delete_color,
  output logic [DATA_W-1:0]     effect_substitute_color
);

  localparam int unsigned CNT_W = $clog2(FRAME_PIXELS + 1);

  logic [EFFECT_W-1:0]   r_pend_effect;
  logic [DATA_W-1:0]     r_pend_delete;
  logic [DATA_W-1:0]     r_pend_subst;
  logic                  r_pend_dirty;
  logic                  r_size_err;
  logic [CSR_DATA_W-1:0] r_frames;
  logic [EFFECT_W-1:0]   r_effect;
  logic [DATA_W-1:0]     r_delete;
  logic [DATA_W-1:0]     r_subst;
  logic [CSR_DATA_W-1:0] r_readdata;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_open;

  beat_t                 w_in_beat;
  beat_t                 w_out_beat;
  beat_t                 w_load_beat;
  logic                  w_load;
  logic                  w_accept;
  logic                  w_commit;
  logic                  w_wr_pend;
  logic                  w_clr_err;
  logic                  w_clr_frames;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic                  w_open_nxt;
  logic                  w_frame_err;
  logic [CSR_DATA_W-1:0] w_status;
  logic [CSR_DATA_W-1:0] w_rd_mux;
  logic                  w_unused;

  assign w_in_beat = '{sop: in_sop, eop: in_eop, data: in_data};

  video_stream_skid #(
    .W (BEAT_W)
  ) u_skid (
    .clk           (clk),
    .rst_n         (reset),
    .i_data        (w_in_beat),
    .i_valid       (in_valid),
    .o_ready       (in_ready),
    .o_data        (w_out_beat),
    .o_valid       (out_valid),
    .i_ready       (out_ready),
    .o_load_c      (w_load),
    .o_load_data_c (w_load_beat)
  );

  assign out_data     = w_out_beat.data;
  assign out_sop      = w_out_beat.sop;
  assign out_eop      = w_out_beat.eop;
  assign w_accept     = in_valid & in_ready;
  assign w_commit     = w_load & w_load_beat.sop;
  assign w_wr_pend    = avs_write & (avs_address <= CSR_SUBST);
  assign w_clr_err    = avs_write & (avs_address == CSR_STATUS) & avs_writedata[STATUS_SIZE_ERR_BIT];
  assign w_clr_frames = avs_write & (avs_address == CSR_FRAMES);
  assign w_unused     = ^{avs_writedata[CSR_DATA_W-1:DATA_W], w_load_beat.eop, w_load_beat.data};

  // Frame-size checker; the counter saturates at FRAME_PIXELS so long frames still fail at eop.
  always_comb begin
    w_cnt_nxt   = r_cnt;
    w_open_nxt  = r_open;
    w_frame_err = 1'b0;
    if (w_accept) begin
      if (in_sop) begin
        w_frame_err = r_open;
        w_cnt_nxt   = CNT_W'(1);
        w_open_nxt  = 1'b1;
        if (in_eop) begin
          w_open_nxt = 1'b0;
          if (FRAME_PIXELS != 1) begin
            w_frame_err = 1'b1;
          end
        end
      end else if (!r_open) begin
        w_frame_err = 1'b1;
      end else begin
        if (r_cnt != CNT_W'(FRAME_PIXELS)) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
        if (in_eop) begin
          w_open_nxt = 1'b0;
          if (r_cnt != CNT_W'(FRAME_PIXELS - 1)) begin
            w_frame_err = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    w_status                      = '0;
    w_status[STATUS_DIRTY_BIT]    = r_pend_dirty;
    w_status[STATUS_SIZE_ERR_BIT] = r_size_err;
    w_rd_mux                      = '0;
    case (avs_address)
      CSR_EFFECT: w_rd_mux = CSR_DATA_W'(r_pend_effect);
      CSR_DELETE: w_rd_mux = CSR_DATA_W'(r_pend_delete);
      CSR_SUBST:  w_rd_mux = CSR_DATA_W'(r_pend_subst);
      CSR_STATUS: w_rd_mux = w_status;
      CSR_FRAMES: w_rd_mux = r_frames;
      CSR_ACTIVE: w_rd_mux = CSR_DATA_W'(r_effect);
      default:    w_rd_mux = '0;
    endcase
  end

  // A commit samples pending before any same-edge CSR write lands.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pend_effect <= FX_NONE;
      r_pend_delete <= DELETE_COLOR_RST;
      r_pend_subst  <= SUBST_COLOR_RST;
      r_pend_dirty  <= 1'b0;
      r_size_err    <= 1'b0;
      r_frames      <= '0;
      r_effect      <= FX_NONE;
      r_delete      <= DELETE_COLOR_RST;
      r_subst       <= SUBST_COLOR_RST;
      r_readdata    <= '0;
      r_cnt         <= '0;
      r_open        <= 1'b0;
    end else begin
      if (avs_write) begin
        case (avs_address)
          CSR_EFFECT: r_pend_effect <= avs_writedata[EFFECT_W-1:0];
          CSR_DELETE: r_pend_delete <= avs_writedata[DATA_W-1:0];
          CSR_SUBST:  r_pend_subst  <= avs_writedata[DATA_W-1:0];
          default:    ;
        endcase
      end
      if (w_wr_pend) begin
        r_pend_dirty <= 1'b1;
      end else if (w_commit) begin
        r_pend_dirty <= 1'b0;
      end
      if (w_commit) begin
        r_effect <= r_pend_effect;
        r_delete <= r_pend_delete;
        r_subst  <= r_pend_subst;
      end
      if (w_frame_err) begin
        r_size_err <= 1'b1;
      end else if (w_clr_err) begin
        r_size_err <= 1'b0;
      end
      if (w_clr_frames) begin
        r_frames <= '0;
      end else if (w_accept && in_eop) begin
        r_frames <= r_frames + CSR_DATA_W'(1);
      end
      r_cnt      <= w_cnt_nxt;
      r_open     <= w_open_nxt;
      r_readdata <= avs_read ? w_rd_mux : '0;
    end
  end

  assign avs_readdata            = r_readdata;
  assign effect                  = r_effect;
  assign effect_delete_color     = r_delete;
  assign effect_substitute_color = r_subst;

endmodule
